dmem_bus_bridge: RTL and testbench
==================================

DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 255: bus cycles spent in WAIT before timeout.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port en_in, input, 1 bit: global run enable from the system.
REQ-005 SHALL have port cpu_en, output, 1 bit: pipeline enable to the CPU.
REQ-006 SHALL have port cpu_mem_write_en, input, 4 bits: CPU X-stage byte write enables.
REQ-007 SHALL have port cpu_mem_read_en, input, 1 bit: CPU X-stage read request.
REQ-008 SHALL have port cpu_mem_addr, input, 32 bits: CPU X-stage byte address.
REQ-009 SHALL have port cpu_mem_write_data, input, 32 bits: CPU store data, already byte-lane replicated.
REQ-010 SHALL have port cpu_mem_read_data, output, 32 bits: load data for the CPU M stage.
REQ-011 SHALL have port bus_req, output, 1 bit: bus request.
REQ-012 SHALL have port bus_we, output, 4 bits: bus byte write enables; 0 means read.
REQ-013 SHALL have port bus_addr, output, 32 bits: bus address.
REQ-014 SHALL have port bus_wdata, output, 32 bits: bus write data.
REQ-015 SHALL have port bus_ack, input, 1 bit: bus completion, one-cycle pulse.
REQ-016 SHALL have port bus_rdata, input, 32 bits: read data, valid when bus_ack=1.
REQ-017 SHALL have port bus_err, output, 1 bit: sticky timeout flag.

Function
REQ-018 SHALL implement states IDLE, WAIT and DONE.
REQ-019 SHALL define access = cpu_mem_read_en | (|cpu_mem_write_en).
REQ-020 IDLE with en_in=1 and access=1 SHALL, in the same cycle, drive cpu_en=0, latch addr, wdata and we into bus_addr, bus_wdata and bus_we, and go to WAIT.
- Reads SHALL latch bus_we=0.
- If both read and write are asserted, write SHALL win.
REQ-021 IDLE with access=0 SHALL drive cpu_en=en_in; IDLE with en_in=0 SHALL ignore access.
REQ-022 WAIT SHALL hold bus_req=1 and keep bus_addr, bus_wdata and bus_we stable; cpu_en SHALL be 0.
REQ-023 WAIT with bus_ack=1 SHALL capture bus_rdata into an internal pending register (reads only), clear bus_req next edge and go to DONE.
REQ-024 WAIT SHALL count cycles; when the count reaches MAX_WAIT without ack, the bridge SHALL set bus_err=1, set pending to 0, and go to DONE.
- Ack in the same cycle as the count reaching MAX_WAIT SHALL win; no error is raised.
REQ-025 DONE SHALL drive cpu_en=en_in and SHALL NOT issue a new bus request even though the CPU still presents the same access.
- DONE with en_in=1 SHALL copy pending into cpu_mem_read_data (reads only) and go to IDLE.
- DONE with en_in=0 SHALL remain in DONE.
REQ-026 cpu_mem_read_data SHALL change only on the DONE exit edge, so load data appears exactly one cycle after the CPU-advancing cycle.
- It SHALL be held unchanged across all subsequent stalls, including back-to-back loads.
REQ-027 bus_req SHALL be registered; it SHALL be high only in WAIT.
REQ-028 The bus handshake SHALL continue while en_in=0.
REQ-029 bus_ack arriving outside WAIT SHALL be ignored.
REQ-030 Minimum access cost SHALL be: 1 IDLE-detect cycle, 1 or more WAIT cycles, then 1 DONE cycle.
REQ-031 bus_err SHALL stay 1 until reset.

Reset
REQ-032 While rst=0 at a clock edge, the bridge SHALL take these values: state IDLE, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, cpu_mem_read_data 0, pending 0, wait counter 0, bus_err 0.
REQ-033 cpu_en SHALL be 0 while rst=0.
REQ-034 Reset asserted in WAIT or DONE SHALL abandon the access and drop bus_req at that edge.

Verification
REQ-035 Read, ack after 3 WAIT cycles: addr 0x100, bus_rdata 0xCAFEF00D -> cpu_en=0 for 4 cycles, then DONE; cpu_mem_read_data=0xCAFEF00D the cycle after DONE; bus_we=0.
REQ-036 Byte store, cpu_mem_write_en=4'b0010, data 0x41414141, ack after 1 cycle -> bus_we=4'b0010 held through WAIT; exactly one bus_req episode; cpu_mem_read_data unchanged.
REQ-037 Back-to-back loads, rdata 0x11111111 then 0x22222222 -> output reads 0x11111111 throughout the second stall and becomes 0x22222222 only after the second DONE.
REQ-038 No ack, MAX_WAIT=4 -> bus_req high for 4 cycles, bus_err=1, cpu_mem_read_data=0, CPU released; a second access then proceeds normally with bus_err still 1.
REQ-039 Ack in the same cycle the counter reaches MAX_WAIT -> bus_err stays 0 and the data is delivered.
REQ-040 Reset mid-WAIT, plus en_in=0 held in DONE for 5 cycles -> reset drops bus_req at that edge and returns to IDLE; en_in low holds DONE with cpu_en=0 and no second request.

Source files
------------

// File: rtl/dmem_bus_bridge.sv
// Data-memory bridge: stalls the CPU pipeline while a single load/store is
// carried out over a request/ack bus, with a sticky timeout flag.
module dmem_bus_bridge #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  output logic        cpu_en,
  input  logic [3:0]  cpu_mem_write_en,
  input  logic        cpu_mem_read_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_write_data,
  output logic [31:0] cpu_mem_read_data,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  localparam int unsigned CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state_q, state_d;
  logic          bus_req_q, bus_req_d;
  logic [3:0]    bus_we_q, bus_we_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [31:0]   pend_q, pend_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          bus_err_q, bus_err_d;
  logic          cpu_en_c;
  logic          access;

  assign access = cpu_mem_read_en | (|cpu_mem_write_en);

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rd_data_d   = rd_data_q;
    pend_d      = pend_q;
    wait_cnt_d  = wait_cnt_q;
    bus_err_d   = bus_err_q;
    cpu_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        cpu_en_c = en_in;
        if (en_in && access) begin
          cpu_en_c    = 1'b0;
          // Write enables pass straight through: a pure read latches 0,
          // and any set byte lane makes the access a write.
          bus_we_d    = cpu_mem_write_en;
          bus_addr_d  = cpu_mem_addr;
          bus_wdata_d = cpu_mem_write_data;
          wait_cnt_d  = '0;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          if (bus_we_q == 4'b0000) pend_d = bus_rdata;
          wait_cnt_d = '0;
          state_d    = DONE;
        end else if (wait_cnt_q == LAST_CNT) begin
          bus_err_d  = 1'b1;
          pend_d     = '0;
          wait_cnt_d = '0;
          state_d    = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DONE: begin
        // The CPU advances here; load data lands on the following edge.
        cpu_en_c = en_in;
        if (en_in) begin
          if (bus_we_q == 4'b0000) rd_data_d = pend_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    bus_req_d = (state_d == WAIT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rd_data_q   <= '0;
      pend_q      <= '0;
      wait_cnt_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rd_data_q   <= rd_data_d;
      pend_q      <= pend_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign cpu_en            = cpu_en_c & rst;
  assign cpu_mem_read_data = rd_data_q;
  assign bus_req           = bus_req_q;
  assign bus_we            = bus_we_q;
  assign bus_addr          = bus_addr_q;
  assign bus_wdata         = bus_wdata_q;
  assign bus_err           = bus_err_q;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboarded bench for dmem_bus_bridge: the bench acts as CPU and bus slave.
module tb_dmem_bus_bridge;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_in;
  logic        cpu_en;
  logic [3:0]  cpu_mem_write_en;
  logic        cpu_mem_read_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        bus_err;

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_rd = '0;
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  dmem_bus_bridge #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .cpu_en(cpu_en),
    .cpu_mem_write_en(cpu_mem_write_en), .cpu_mem_read_en(cpu_mem_read_en),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read_data(cpu_mem_read_data), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_cpu();
    cpu_mem_write_en = 4'b0000;
    cpu_mem_read_en  = 1'b0;
  endtask

  // One access from IDLE through DONE exit; the slave acks in WAIT cycle
  // ack_at (0 = never). Leaves the access presented on return.
  task automatic do_access(input logic [3:0] we, input logic re, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_at, input int done_hold);
    logic       to;
    int         nreq;
    int         exp_req;
    logic [31:0] got_sb;
    to      = (ack_at == 0) || (ack_at > MAXW);
    exp_req = to ? MAXW : ack_at;
    if (we == 4'b0000) sb.push_back(to ? 32'h0 : rd);
    else               sb.push_back(exp_rd);
    cpu_mem_write_en   = we;
    cpu_mem_read_en    = re;
    cpu_mem_addr       = addr;
    cpu_mem_write_data = wd;
    en_in              = 1'b1;
    #1;
    chk("idle_stall", 32'(cpu_en), 32'h0);
    chk("idle_noreq", 32'(bus_req), 32'h0);
    step();
    nreq = 0;
    while (bus_req === 1'b1 && nreq < 300) begin
      nreq++;
      chk("wait_cpu_en", 32'(cpu_en), 32'h0);
      chk("wait_we", 32'(bus_we), 32'(we));
      chk("wait_addr", bus_addr, addr);
      chk("wait_wdata", bus_wdata, wd);
      chk("wait_rd_hold", cpu_mem_read_data, exp_rd);
      bus_ack   = (nreq == ack_at);
      bus_rdata = (nreq == ack_at) ? rd : (32'hDEAD0000 | 32'(nreq));
      step();
      bus_ack = 1'b0;
    end
    chk("req_cycles", 32'(nreq), 32'(exp_req));
    exp_err = exp_err | to;
    chk("bus_err", 32'(bus_err), 32'(exp_err));
    for (int h = 0; h < done_hold; h++) begin
      en_in = 1'b0;
      #1;
      chk("hold_cpu_en", 32'(cpu_en), 32'h0);
      chk("hold_noreq", 32'(bus_req), 32'h0);
      chk("hold_rd", cpu_mem_read_data, exp_rd);
      step();
    end
    en_in = 1'b1;
    #1;
    chk("done_cpu_en", 32'(cpu_en), 32'h1);
    chk("done_noreq", 32'(bus_req), 32'h0);
    chk("done_rd_old", cpu_mem_read_data, exp_rd);
    step();
    chk("post_noreq", 32'(bus_req), 32'h0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'h1, 32'h0);
    end else begin
      got_sb = sb.pop_front();
      chk("rd_data", cpu_mem_read_data, got_sb);
      exp_rd = got_sb;
    end
  endtask

  initial begin
    rst = 1'b0; en_in = 1'b1; bus_ack = 1'b0; bus_rdata = '0;
    cpu_mem_addr = '0; cpu_mem_write_data = '0;
    clr_cpu();
    step();
    step();
    chk("rst_cpu_en", 32'(cpu_en), 32'h0);
    chk("rst_req", 32'(bus_req), 32'h0);
    chk("rst_we", 32'(bus_we), 32'h0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_wdata", bus_wdata, 32'h0);
    chk("rst_rd", cpu_mem_read_data, 32'h0);
    chk("rst_err", 32'(bus_err), 32'h0);
    rst = 1'b1;
    #1;
    chk("idle_run", 32'(cpu_en), 32'h1);
    step();

    do_access(4'b0000, 1'b1, 32'h100, 32'h0, 32'hCAFEF00D, 3, 0);
    clr_cpu(); step();
    do_access(4'b0010, 1'b0, 32'h204, 32'h41414141, 32'h0BADBAD0, 1, 0);
    clr_cpu(); step();
    do_access(4'b0000, 1'b1, 32'h300, 32'h0, 32'h11111111, 2, 0);
    do_access(4'b0000, 1'b1, 32'h304, 32'h0, 32'h22222222, 1, 0);
    do_access(4'b1100, 1'b1, 32'h308, 32'h55AA55AA, 32'h99999999, 2, 0);
    do_access(4'b0000, 1'b1, 32'h30C, 32'h0, 32'h44444444, MAXW, 0);
    clr_cpu(); step();
    do_access(4'b0000, 1'b1, 32'h400, 32'h0, 32'h77777777, 0, 0);
    clr_cpu(); step();
    do_access(4'b0000, 1'b1, 32'h404, 32'h0, 32'h12345678, 2, 0);
    clr_cpu(); step();

    // reset in the middle of WAIT
    cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h500;
    step();
    chk("rw_req1", 32'(bus_req), 32'h1);
    step();
    chk("rw_req2", 32'(bus_req), 32'h1);
    rst = 1'b0;
    step();
    chk("rw_req_drop", 32'(bus_req), 32'h0);
    chk("rw_cpu_en", 32'(cpu_en), 32'h0);
    chk("rw_err_clr", 32'(bus_err), 32'h0);
    chk("rw_rd_clr", cpu_mem_read_data, 32'h0);
    rst = 1'b1; exp_rd = '0; exp_err = 1'b0;
    clr_cpu();
    #1;
    chk("rw_idle", 32'(cpu_en), 32'h1);
    step();
    do_access(4'b0000, 1'b1, 32'h600, 32'h0, 32'hA5A5A5A5, 1, 5);
    clr_cpu(); step();

    // en_in low in IDLE ignores access; stray ack is ignored
    en_in = 1'b0; cpu_mem_read_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("off_cpu_en", 32'(cpu_en), 32'h0);
      chk("off_noreq", 32'(bus_req), 32'h0);
      step();
    end
    en_in = 1'b1; clr_cpu();
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    step();
    bus_ack = 1'b0;
    chk("stray_noreq", 32'(bus_req), 32'h0);
    chk("stray_cpu_en", 32'(cpu_en), 32'h1);
    chk("stray_rd", cpu_mem_read_data, exp_rd);
    do_access(4'b0001, 1'b0, 32'h700, 32'h33333333, 32'h0, 1, 0);
    clr_cpu(); step();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
